// File: rtl/apb_pkg.sv
// Shared APB definitions: bus state encoding (also used by the APB slave),
// default bus widths and a small index-width helper.
// Purely declarative; no logic, no latency, no flow control.
package apb_pkg;

  // APB transfer phase, shared with the slave side
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  // Width of a binary index into n items, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_master_rr_arbiter.sv
// Round-robin priority rotation: first set request at or above ptr, with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; grant is suppressed entirely while en is low.
module rr_arbiter
  import apb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);

  logic [IW-1:0] cand;

  // Walk the requesters starting at ptr; the first set one wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = IW'((int'(ptr) + off) % NREQ);
      if (en && !gnt_vld && req[cand]) begin
        gnt_vld   = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master sharing one APB slave port among NREQ requesters.
// Latency: grant edge -> SETUP -> ACCESS -> done; 3 cycles minimum, +1 per wait state.
// Backpressure: p_ready stretches ACCESS; requesters hold req until their done pulse.
// Optional: APB_MASTER_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int AW             = APB_AW,
  parameter int DW             = APB_DW,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              p_clk,
  input  logic              p_reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_slverr,
  output logic [AW-1:0]     p_add,
  output logic              p_sel,
  output logic              p_enable,
  output logic              p_write,
  output logic [DW-1:0]     p_wdata,
  input  logic [DW-1:0]     p_rdata,
  input  logic              p_ready,
  input  logic              p_slverr
);

  localparam int IW = idx_width(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_rr_master: unsupported parameter set");
  end

  apb_state_e      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] owner_oh_q, owner_oh_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   p_add_q, p_add_d;
  logic [DW-1:0]   p_wdata_q, p_wdata_d;
  logic            p_write_q, p_write_d;
  logic            p_sel_q, p_sel_d;
  logic            p_enable_q, p_enable_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_slverr_q, rsp_slverr_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TW = idx_width(TIMEOUT_CYCLES);
  logic [TW-1:0]   cnt_q, cnt_d;
`endif

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_vld;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .en      (state_q == IDLE),
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Next-state and registered-output computation for the APB phase sequence
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    owner_oh_d   = owner_oh_q;
    ptr_d        = ptr_q;
    p_add_d      = p_add_q;
    p_wdata_d    = p_wdata_q;
    p_write_d    = p_write_q;
    p_sel_d      = p_sel_q;
    p_enable_d   = p_enable_q;
    done_d       = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        p_sel_d    = 1'b0;
        p_enable_d = 1'b0;
        if (gnt_vld) begin
          // Request fields are captured here so the requester is free to change them
          owner_d    = gnt_idx;
          owner_oh_d = gnt;
          p_add_d    = req_addr[int'(gnt_idx)*AW +: AW];
          p_wdata_d  = req_wdata[int'(gnt_idx)*DW +: DW];
          p_write_d  = req_write[gnt_idx];
          p_sel_d    = 1'b1;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        p_sel_d    = 1'b1;
        p_enable_d = 1'b1;
        state_d    = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d      = '0;
`endif
      end
      ACCESS: begin
        if (p_ready) begin
          state_d      = IDLE;
          p_sel_d      = 1'b0;
          p_enable_d   = 1'b0;
          done_d       = owner_oh_q;
          rsp_rdata_d  = p_write_q ? '0 : p_rdata;
          rsp_slverr_d = p_slverr;
          ptr_d        = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
        end
`ifdef APB_MASTER_TIMEOUT_EN
        // Last permitted wait cycle with no ready: abort as a slave error
        else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d      = IDLE;
          p_sel_d      = 1'b0;
          p_enable_d   = 1'b0;
          done_d       = owner_oh_q;
          rsp_rdata_d  = '0;
          rsp_slverr_d = 1'b1;
          ptr_d        = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
`endif
      end
      default: begin
        state_d    = IDLE;
        p_sel_d    = 1'b0;
        p_enable_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transfer silently
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      owner_oh_q   <= '0;
      ptr_q        <= '0;
      p_add_q      <= '0;
      p_wdata_q    <= '0;
      p_write_q    <= 1'b0;
      p_sel_q      <= 1'b0;
      p_enable_q   <= 1'b0;
      done_q       <= '0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      owner_oh_q   <= owner_oh_d;
      ptr_q        <= ptr_d;
      p_add_q      <= p_add_d;
      p_wdata_q    <= p_wdata_d;
      p_write_q    <= p_write_d;
      p_sel_q      <= p_sel_d;
      p_enable_q   <= p_enable_d;
      done_q       <= done_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign done       = done_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;
  assign p_add      = p_add_q;
  assign p_sel      = p_sel_q;
  assign p_enable   = p_enable_q;
  assign p_write    = p_write_q;
  assign p_wdata    = p_wdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: directed scenarios plus randomized requesters,
// a modelled APB memory slave and a transaction-level reference model.
module tb_apb_rr_master;

  localparam int NREQ = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_ON = 1'b1;
`else
  localparam int TO    = 16;
  localparam bit TO_ON = 1'b0;
`endif

  logic              p_clk = 1'b0;
  logic              p_reset;
  logic [NREQ-1:0]   req, req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   done;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_slverr;
  logic [AW-1:0]     p_add;
  logic              p_sel, p_enable, p_write;
  logic [DW-1:0]     p_wdata, p_rdata;
  logic              p_ready, p_slverr;

  apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .p_clk(p_clk), .p_reset(p_reset), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .p_add(p_add),
    .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_ready(p_ready), .p_slverr(p_slverr)
  );

  always #5 p_clk = ~p_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_on = 1'b1;

  // Slave memory (written from the DUT bus) and reference memory (written by the model)
  logic [DW-1:0] slave_mem [16];
  logic [DW-1:0] ref_mem   [16];
  int acc_cnt  = 0;
  int cur_wait = 0;
  int wait_plan = 0;

  // Transaction-level model: one transfer at a time, timeline measured from the grant edge
  bit              m_busy = 1'b0;
  bit              m_to   = 1'b0;
  int              m_ptr = 0, m_owner = 0, m_age = 0, m_end = 0, m_w = 0;
  logic            e_sel = 1'b0, e_en = 1'b0, e_write = 1'b0, e_slverr = 1'b0, e_rst = 1'b0;
  logic [AW-1:0]   e_add = '0;
  logic [DW-1:0]   e_wdata = '0, e_rdata = '0;
  logic [NREQ-1:0] e_done = '0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge p_clk) begin
    int  c, win;
    bit  found;
    e_done = '0;
    e_rst  = 1'b0;
    if (p_reset) begin
      m_busy = 1'b0; m_ptr = 0;
      e_sel = 1'b0; e_en = 1'b0; e_add = '0; e_wdata = '0; e_write = 1'b0;
      e_rdata = '0; e_slverr = 1'b0; e_rst = 1'b1;
    end else if (m_busy) begin
      m_age++;
      if (m_age == m_end) begin
        m_busy = 1'b0;
        e_sel = 1'b0; e_en = 1'b0;
        e_done[m_owner] = 1'b1;
        if (m_to) begin
          e_rdata = '0; e_slverr = 1'b1;
        end else begin
          e_rdata  = e_write ? '0 : ref_mem[e_add[5:2]];
          e_slverr = e_add[6];
          if (e_write) ref_mem[e_add[5:2]] = e_wdata;
        end
        m_ptr = (m_owner + 1) % NREQ;
      end else begin
        e_sel = 1'b1; e_en = 1'b1;
      end
    end else begin
      found = 1'b0; win = 0;
      for (int off = 0; off < NREQ; off++) begin
        c = (m_ptr + off) % NREQ;
        if (!found && req[c]) begin found = 1'b1; win = c; end
      end
      e_sel = found; e_en = 1'b0;
      if (found) begin
        m_busy = 1'b1; m_age = 1; m_owner = win;
        e_add   = req_addr[win*AW +: AW];
        e_wdata = req_wdata[win*DW +: DW];
        e_write = req_write[win];
        m_w = (wait_plan >= 0) ? wait_plan : int'($urandom_range(0, 3));
        cur_wait = m_w;
        m_to  = TO_ON && (m_w >= TO);
        m_end = m_to ? TO + 2 : m_w + 3;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge p_clk) begin
    if (chk_on) begin
      cmp("p_sel", p_sel, e_sel);
      cmp("p_enable", p_enable, e_en);
      cmp("p_add", p_add, e_add);
      cmp("p_wdata", p_wdata, e_wdata);
      cmp("p_write", p_write, e_write);
      cmp("done", done, e_done);
      if (e_done != '0 || e_rst) begin
        cmp("rsp_rdata", rsp_rdata, e_rdata);
        cmp("rsp_slverr", rsp_slverr, e_slverr);
      end
    end
  end

  task automatic slave_drive();
    if (p_sel === 1'b1 && p_enable === 1'b1) begin
      acc_cnt++;
      if (acc_cnt > cur_wait) begin
        p_ready  = 1'b1;
        p_slverr = p_add[6];
        p_rdata  = slave_mem[p_add[5:2]];
        if (p_write) slave_mem[p_add[5:2]] = p_wdata;
      end else begin
        p_ready  = 1'b0;
        p_rdata  = $urandom;
        p_slverr = 1'($urandom_range(0, 1));
      end
    end else begin
      acc_cnt  = 0;
      p_ready  = 1'($urandom_range(0, 1));
      p_rdata  = $urandom;
      p_slverr = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic step();
    @(negedge p_clk);
    cyc++;
    slave_drive();
  endtask

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_done(output int who, output int at);
    who = -1; at = -1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done !== '0) begin
        for (int i = 0; i < NREQ; i++) if (done[i] === 1'b1) who = i;
        at = cyc;
        return;
      end
    end
    n_cmp++; n_bad++;
    $display("FAIL wait_done: no done pulse within 40 cycles (cycle %0d)", cyc);
  endtask

  initial begin
    int who, at, prev, start;
    bit [NREQ-1:0] pend;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = 32'h1000_0000 + i * 32'h0101;
      ref_mem[i]   = 32'h1000_0000 + i * 32'h0101;
    end
    p_reset = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    p_ready = 1'b0; p_rdata = '0; p_slverr = 1'b0;
    step(); step();
    cmp("rst_p_sel", p_sel, 0);
    cmp("rst_done", done, 0);
    cmp("rst_rdata", rsp_rdata, 0);
    p_reset = 1'b0;

    // Single write from requester 0
    wait_plan = 0;
    set_req(0, 1'b1, 32'h4, 32'hDEADBEEF);
    step();
    cmp("wr_setup_sel", p_sel, 1);
    cmp("wr_setup_en", p_enable, 0);
    cmp("wr_setup_add", p_add, 32'h4);
    cmp("wr_setup_write", p_write, 1);
    step();
    cmp("wr_access_en", p_enable, 1);
    step();
    cmp("wr_done", done, 3'b001);
    cmp("wr_slverr", rsp_slverr, 0);
    req = '0;

    // Read back through requester 1
    set_req(1, 1'b0, 32'h4, 32'h0);
    step(); step(); step();
    cmp("rd_done", done, 3'b010);
    cmp("rd_data", rsp_rdata, 32'hDEADBEEF);
    req = '0;

    // Two requesters held high: pointer is at 2, so order is 0,1,0,1
    set_req(0, 1'b0, 32'h8, 32'h0);
    set_req(1, 1'b0, 32'h10, 32'h0);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_done(who, at);
      cmp("fair_owner", who, k % 2);
      if (k > 0) cmp("fair_gap", at - prev, 3);
      prev = at;
    end
    req = '0;

    // Five wait states on a read from requester 2
    wait_plan = 5;
    set_req(2, 1'b0, 32'h8, 32'h0);
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      cmp("ws_sel_en", {p_sel, p_enable}, 2'b11);
      cmp("ws_add", p_add, 32'h8);
    end
    step();
    cmp("ws_done", done, 3'b100);
    req = '0;

    // Reset in ACCESS, with the pointer parked at 1 beforehand
    wait_plan = 0;
    set_req(0, 1'b1, 32'hC, 32'h0BAD_F00D);
    wait_done(who, at);
    req = '0;
    wait_plan = 100;
    set_req(1, 1'b0, 32'h14, 32'h0);
    step(); step(); step(); step();
    p_reset = 1'b1;
    step();
    cmp("rst_mid_sel", p_sel, 0);
    cmp("rst_mid_en", p_enable, 0);
    cmp("rst_mid_done", done, 0);
    p_reset = 1'b0;
    wait_plan = 0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'h18, 32'h0);
    wait_done(who, at);
    cmp("rst_regrant", who, 0);
    req = '0;

`ifdef APB_MASTER_TIMEOUT_EN
    // Slave never ready: aborted after TO wait cycles
    step();
    wait_plan = 100;
    set_req(0, 1'b0, 32'h10, 32'h0);
    start = cyc;
    wait_done(who, at);
    cmp("to_owner", who, 0);
    cmp("to_latency", at - start, TO + 2);
    cmp("to_slverr", rsp_slverr, 1);
    cmp("to_rdata", rsp_rdata, 0);
    req = '0;
`endif

    // Randomized requesters
    step(); step();
    wait_plan = -1;
    pend = '0;
    for (int n = 0; n < 800; n++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            pend[i] = 1'b1;
            set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31) * 4), $urandom);
          end
        end else if (e_done[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31) * 4), $urandom);
          else begin
            pend[i] = 1'b0;
            req[i] = 1'b0;
          end
        end else if (req[i] && m_busy && m_owner == i && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b0;
          req_addr[i*AW +: AW] = $urandom;
          req_wdata[i*DW +: DW] = $urandom;
        end
      end
    end
    req = '0;
    repeat (20) step();
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin APB master that shares one APB slave port (p_sel/p_enable/p_add/p_wdata) between NREQ local requesters.
- Each requester issues a single read or write and holds it until its done pulse.
- The block sequences the APB IDLE -> SETUP -> ACCESS protocol and returns p_rdata/p_slverr to the winning requester.
- Sits between bus clients (DMA, CPU bridge, config engine) and the APB memory slave.

Parameters:
- NREQ, 2: number of requesters (2..8).
- AW, 32: APB address width.
- DW, 32: APB data width.
- TIMEOUT_CYCLES, 16: ACCESS-phase wait limit; used only with the optional feature.

Ports:
- p_clk  in  1  clock; all logic on the rising edge.
- p_reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request, level.
- req_write  in  NREQ  per-requester direction; 1 = write.
- req_addr  in  NREQ*AW  packed addresses; requester i occupies [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data; same packing as req_addr.
- done  out  NREQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DW  read data, valid while done is high.
- rsp_slverr  out  1  slave error, valid while done is high.
- p_add  out  AW  APB address.
- p_sel  out  1  APB select.
- p_enable  out  1  APB enable.
- p_write  out  1  APB direction.
- p_wdata  out  DW  APB write data.
- p_rdata  in  DW  APB read data.
- p_ready  in  1  APB ready.
- p_slverr  in  1  APB slave error.

Behaviour:
- All outputs are registered.
- Reset values: p_sel=0, p_enable=0, p_write=0, p_add=0, p_wdata=0, done=0, rsp_rdata=0, rsp_slverr=0, state=IDLE, rr pointer=0.
- Reset takes effect at the next edge regardless of state. An in-flight transfer is dropped: no done pulse, and the bus returns to idle values.
- States: IDLE, SETUP, ACCESS (2-bit encoding in the shared package).
- IDLE:
  - If any req bit is set, pick the first set bit searching from the rr pointer upward with wrap.
  - Latch owner index, addr, wdata and write into the bus registers, then go to SETUP.
  - Otherwise stay in IDLE with p_sel=0 and p_enable=0.
- SETUP: p_sel=1, p_enable=0 for exactly one cycle, then go to ACCESS.
- ACCESS: p_sel=1, p_enable=1. Hold until p_ready=1 is sampled (wait states unbounded without the optional feature).
- On sampling p_ready=1:
  - Go to IDLE and drop p_sel and p_enable.
  - Pulse done[owner] for one cycle.
  - Load rsp_rdata with p_rdata on reads and 0 on writes; load rsp_slverr with p_slverr.
  - Set the rr pointer to (owner+1) mod NREQ.
- Minimum transfer: request seen at edge k -> SETUP in cycle k+1, ACCESS in cycle k+2, done in cycle k+3 when p_ready is already 1.
- A completion always passes through one IDLE cycle before the next SETUP, so back-to-back transfers occupy 3 cycles each.
- Address, wdata and write are latched at grant. Requester inputs may change or deassert after the grant cycle without affecting the bus. A dropped req still gets its done pulse.
- A requester that keeps req high after done is treated as a new request and re-arbitrated in the same IDLE cycle.
- Simultaneous requests are served in round-robin order; no requester waits more than NREQ-1 transfers.
- p_add, p_write and p_wdata stay stable from SETUP through the final ACCESS cycle, and keep their last values while in IDLE.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and counts each cycle p_ready=0.
  - When it reaches TIMEOUT_CYCLES, the transfer is aborted: go to IDLE, pulse done[owner], rsp_slverr=1, rsp_rdata=0, rr pointer advances.
  - p_ready in the same cycle as the limit wins, giving a normal completion.
- Undefined: no counter logic; ACCESS waits indefinitely.

Decomposition:
- Package apb_pkg: state typedef (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) shared with the APB slave, plus default width constants.
- One natural sub-module: rr_arbiter. It takes a req vector, the pointer and an enable, and returns a one-hot grant plus a binary index. It is purely combinational priority rotation; the pointer register lives in the top.

Test Plan:
- Write: req[0] with addr=0x04, wdata=0xDEADBEEF, slave ready in ACCESS -> SETUP cycle shows p_add=0x04, p_write=1, p_enable=0; next cycle p_enable=1; done=2'b01 one cycle later, rsp_slverr=0.
- Read back: req[1] read addr=0x04 -> rsp_rdata=0xDEADBEEF with done=2'b10.
- Fairness: both req held high for 4 transfers, pointer=0 -> grant order 0,1,0,1; each done pulse 3 cycles apart.
- Wait states: p_ready held low 5 ACCESS cycles -> p_sel=1, p_enable=1 and p_add stable throughout; done in the cycle after p_ready rises.
- Reset mid-transfer: assert p_reset during ACCESS -> next cycle p_sel=0, p_enable=0, done=0, and the next grant goes to requester 0.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4: p_ready stuck low -> done after 4 ACCESS wait cycles with rsp_slverr=1 and rsp_rdata=0.
